// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: decode/back-end handshake bundle for the hazard scoreboard.
interface hazard_scoreboard_if #(
  parameter int STAGES = 3,
  parameter int REG_ADDR_W = 9
);
  logic issue_valid_in;
  logic [REG_ADDR_W-1:0] rs1_in;
  logic rs1_read_in;
  logic [REG_ADDR_W-1:0] rs2_in;
  logic rs2_read_in;
  logic [REG_ADDR_W-1:0] rd_in;
  logic rd_write_in;
  logic is_load_in;
  logic fence_in;
  logic advance_in;
  logic flush_in;
  logic stall_out;
  logic [STAGES-1:0] rs1_fwd_out;
  logic [STAGES-1:0] rs2_fwd_out;
  logic [$clog2(STAGES+1)-1:0] pending_out;
  logic [31:0] stall_count_out;
  modport master (
    output issue_valid_in, rs1_in, rs1_read_in, rs2_in, rs2_read_in, rd_in, rd_write_in,
           is_load_in, fence_in, advance_in, flush_in,
    input  stall_out, rs1_fwd_out, rs2_fwd_out, pending_out, stall_count_out
  );
  modport slave (
    input  issue_valid_in, rs1_in, rs1_read_in, rs2_in, rs2_read_in, rd_in, rd_write_in,
           is_load_in, fence_in, advance_in, flush_in,
    output stall_out, rs1_fwd_out, rs2_fwd_out, pending_out, stall_count_out
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: STAGES-deep in-flight destination scoreboard producing decode stall and one-hot bypass selects.
// Define HAZARD_STALL_COUNT_EN to enable the 32-bit RAW/fence stall cycle counter.
module hazard_scoreboard #(
  parameter int STAGES = 3,
  parameter int REG_ADDR_W = 9,
  parameter logic [STAGES-1:0] FWD_MASK = {STAGES{1'b1}},
  parameter int LOAD_FWD_STAGE = 1,
  parameter int FLUSH_DEPTH = 2
) (
  input logic clk,
  input logic reset_n_in,
  hazard_scoreboard_if.slave sb
);
  localparam int PW = $clog2(STAGES + 1);
  logic [STAGES-1:0] v, w, ld, hit1, hit2, blk, y1, y2;
  logic [REG_ADDR_W-1:0] rd [STAGES];
  logic b1, b2, stall, take;
  logic [PW-1:0] cnt;
  // Scan oldest to youngest so the lowest matching index wins and shadows older ones.
  always_comb begin
    hit1 = '0;
    hit2 = '0;
    blk = '0;
    y1 = '0;
    y2 = '0;
    b1 = 1'b0;
    b2 = 1'b0;
    cnt = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      hit1[i] = v[i] & w[i] & (rd[i] == sb.rs1_in) & (|sb.rs1_in) & sb.rs1_read_in;
      hit2[i] = v[i] & w[i] & (rd[i] == sb.rs2_in) & (|sb.rs2_in) & sb.rs2_read_in;
      blk[i] = !FWD_MASK[i] | (ld[i] & (i < LOAD_FWD_STAGE));
      cnt = cnt + PW'(v[i]);
      if (hit1[i]) begin
        y1 = '0;
        y1[i] = 1'b1;
        b1 = blk[i];
      end
      if (hit2[i]) begin
        y2 = '0;
        y2[i] = 1'b1;
        b2 = blk[i];
      end
    end
    stall = sb.issue_valid_in & (b1 | b2 | (sb.fence_in & (|v)) | !sb.advance_in);
    take = sb.issue_valid_in & !stall & !sb.flush_in;
  end
  assign sb.stall_out = stall;
  assign sb.rs1_fwd_out = stall ? '0 : y1;
  assign sb.rs2_fwd_out = stall ? '0 : y2;
  assign sb.pending_out = cnt;
  // Flush squash is assigned last so it overrides the shift for the young entries.
  always_ff @(posedge clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      v <= '0;
      w <= '0;
      ld <= '0;
      for (int i = 0; i < STAGES; i++) rd[i] <= '0;
    end else begin
      if (sb.advance_in) begin
        v[0] <= take;
        w[0] <= sb.rd_write_in;
        ld[0] <= sb.is_load_in;
        rd[0] <= sb.rd_in;
        for (int i = 1; i < STAGES; i++) begin
          v[i] <= v[i-1];
          w[i] <= w[i-1];
          ld[i] <= ld[i-1];
          rd[i] <= rd[i-1];
        end
      end
      if (sb.flush_in)
        for (int i = 0; i < STAGES; i++)
          if (i < FLUSH_DEPTH) v[i] <= 1'b0;
    end
  end
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or negedge reset_n_in) begin
    if (!reset_n_in) stall_cnt <= '0;
    else if (stall & sb.advance_in) stall_cnt <= stall_cnt + 32'd1;
  end
  assign sb.stall_count_out = stall_cnt;
`else
  assign sb.stall_count_out = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vector table plus randomized run against a stage-array reference model.
module tb_hazard_scoreboard;
  localparam int S = 3;
  localparam int AW = 9;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hazard_scoreboard_if #(.STAGES(S), .REG_ADDR_W(AW)) intf ();
  hazard_scoreboard #(.STAGES(S), .REG_ADDR_W(AW)) dut (.clk(clk), .reset_n_in(rst_n), .sb(intf.slave));
  typedef struct {
    bit iv; int r1; bit r1r; int r2; bit r2r; int rd; bit w; bit ld; bit fe; bit adv; bit fl;
    bit es; bit [S-1:0] f1; bit [S-1:0] f2; int p;
  } vec_t;
  typedef struct { bit v; int rd; bit w; bit ld; } ent_t;
  ent_t m[S];
  vec_t cur;
  vec_t tbl[22];
  int unsigned mcnt;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic apply();
    intf.issue_valid_in = cur.iv;
    intf.rs1_in = cur.r1[AW-1:0];
    intf.rs1_read_in = cur.r1r;
    intf.rs2_in = cur.r2[AW-1:0];
    intf.rs2_read_in = cur.r2r;
    intf.rd_in = cur.rd[AW-1:0];
    intf.rd_write_in = cur.w;
    intf.is_load_in = cur.ld;
    intf.fence_in = cur.fe;
    intf.advance_in = cur.adv;
    intf.flush_in = cur.fl;
  endtask
  function automatic int youngest(input int rs, input bit rd_flag);
    for (int i = 0; i < S; i++)
      if (m[i].v && m[i].w && m[i].rd == rs && rs != 0 && rd_flag) return i;
    return -1;
  endfunction
  function automatic void model_eval(output bit st, output bit [S-1:0] f1, output bit [S-1:0] f2, output int p);
    int a, b;
    p = 0;
    for (int i = 0; i < S; i++) if (m[i].v) p++;
    a = youngest(cur.r1, cur.r1r);
    b = youngest(cur.r2, cur.r2r);
    st = cur.iv && ((a >= 0 && m[a].ld && a < 1) || (b >= 0 && m[b].ld && b < 1) ||
                    (cur.fe && p != 0) || !cur.adv);
    f1 = (!st && a >= 0) ? (S'(1) << a) : '0;
    f2 = (!st && b >= 0) ? (S'(1) << b) : '0;
  endfunction
  function automatic void model_step(input bit st);
    if (st && cur.adv) mcnt++;
    if (cur.adv) begin
      for (int i = S - 1; i > 0; i--) m[i] = m[i-1];
      m[0] = '{v: cur.iv && !st && !cur.fl, rd: cur.rd, w: cur.w, ld: cur.ld};
    end
    if (cur.fl) for (int i = 0; i < 2; i++) m[i].v = 1'b0;
  endfunction
  function automatic void model_reset();
    for (int i = 0; i < S; i++) m[i] = '{v: 0, rd: 0, w: 0, ld: 0};
    mcnt = 0;
  endfunction
  function automatic logic [31:0] exp_count();
`ifdef HAZARD_STALL_COUNT_EN
    return mcnt;
`else
    return 32'd0;
`endif
  endfunction
  task automatic cycle(input vec_t t, input bit use_tbl, input string tag);
    bit st;
    bit [S-1:0] f1, f2;
    int p;
    cur = t;
    apply();
    #1;
    model_eval(st, f1, f2, p);
    chk({tag, " stall"}, intf.stall_out, st);
    chk({tag, " rs1_fwd"}, intf.rs1_fwd_out, f1);
    chk({tag, " rs2_fwd"}, intf.rs2_fwd_out, f2);
    chk({tag, " pending"}, intf.pending_out, p);
    chk({tag, " count"}, intf.stall_count_out, exp_count());
    if (use_tbl) begin
      chk({tag, " tbl stall"}, intf.stall_out, t.es);
      chk({tag, " tbl rs1_fwd"}, intf.rs1_fwd_out, t.f1);
      chk({tag, " tbl rs2_fwd"}, intf.rs2_fwd_out, t.f2);
      chk({tag, " tbl pending"}, intf.pending_out, t.p);
    end
    @(posedge clk);
    model_step(st);
    @(negedge clk);
  endtask
  task automatic check_zero(input string tag);
    chk({tag, " stall"}, intf.stall_out, 0);
    chk({tag, " rs1_fwd"}, intf.rs1_fwd_out, 0);
    chk({tag, " rs2_fwd"}, intf.rs2_fwd_out, 0);
    chk({tag, " pending"}, intf.pending_out, 0);
    chk({tag, " count"}, intf.stall_count_out, 0);
  endtask
  initial begin
    vec_t r;
    //            iv r1 r1r r2 r2r rd  w ld fe adv fl  es f1 f2 p
    tbl[0]  = '{1, 0, 0, 0, 0, 5,  1, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 5, 1, 0, 0, 6,  1, 0, 0, 1, 0, 1, 0, 0, 1};
    tbl[2]  = '{1, 5, 1, 0, 0, 6,  1, 0, 0, 1, 0, 0, 2, 0, 1};
    tbl[3]  = '{1, 0, 0, 0, 0, 7,  1, 0, 0, 1, 0, 0, 0, 0, 2};
    tbl[4]  = '{1, 0, 0, 7, 1, 7,  1, 0, 0, 1, 0, 0, 0, 1, 2};
    tbl[5]  = '{1, 6, 1, 7, 1, 0,  1, 0, 0, 1, 0, 0, 4, 1, 3};
    tbl[6]  = '{1, 0, 1, 7, 0, 8,  0, 0, 0, 1, 0, 0, 0, 0, 3};
    tbl[7]  = '{1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 0, 0, 3};
    tbl[8]  = '{1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 0, 0, 2};
    tbl[9]  = '{1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1, 0, 0, 1};
    tbl[10] = '{1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[13] = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 1};
    tbl[14] = '{1, 0, 0, 0, 0, 9,  1, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[15] = '{1, 0, 0, 0, 0, 10, 1, 0, 0, 1, 0, 0, 0, 0, 2};
    tbl[16] = '{1, 0, 0, 0, 0, 11, 1, 0, 0, 1, 1, 0, 0, 0, 3};
    tbl[17] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1};
    tbl[18] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[19] = '{1, 0, 0, 0, 0, 12, 1, 0, 0, 1, 0, 0, 0, 0, 0};
    tbl[20] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[21] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0};
    cur = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    apply();
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));
`ifdef HAZARD_STALL_COUNT_EN
    chk("table stall count", intf.stall_count_out, 32'd4);
`else
    chk("table stall count", intf.stall_count_out, 32'd0);
`endif
    // Async reset while decode is stalled on a load-use hazard.
    cycle(tbl[0], 1'b0, "pre_rst_load");
    cur = tbl[1];
    apply();
    #1;
    chk("pre_rst stall", intf.stall_out, 1);
    chk("pre_rst pending", intf.pending_out, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      r.iv = $urandom_range(0, 3) != 0;
      r.r1 = $urandom_range(0, 7);
      r.r1r = $urandom_range(0, 3) != 0;
      r.r2 = $urandom_range(0, 7);
      r.r2r = $urandom_range(0, 3) != 0;
      r.rd = $urandom_range(0, 7);
      r.w = $urandom_range(0, 3) != 0;
      r.ld = $urandom_range(0, 2) == 0;
      r.fe = $urandom_range(0, 9) == 0;
      r.adv = $urandom_range(0, 7) != 0;
      r.fl = $urandom_range(0, 9) == 0;
      r.es = 0;
      r.f1 = 0;
      r.f2 = 0;
      r.p = 0;
      cycle(r, 1'b0, $sformatf("rnd%0d", n));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
